// File: rtl/reg_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_wr_arbiter: round-robin owner of the register bank write port, clears  |
// | r0..r14 after reset and drops writes aimed at the PC register. Rev 1.0      |
// +----------------------------------------------------------------------------+
module reg_wr_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int PC_ADDR = 15,
  parameter int INIT_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3,
  output logic              init_done,
  output logic              pc_wr_err
);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam state_t            RST_STATE = (INIT_EN != 0) ? S_INIT : S_RUN;
  localparam logic [ADDR_W-1:0] PC_A      = PC_ADDR[ADDR_W-1:0];
  // Last register cleared: every address except the top one (the PC).
  localparam logic [ADDR_W-1:0] LAST_INIT = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic              PRIO_A    = 1'b0;
  localparam logic              PRIO_B    = 1'b1;

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic              prio, prio_n;
  logic              we3_n;
  logic [ADDR_W-1:0] wa3_n;
  logic [DATA_W-1:0] wd3_n;
  logic              init_done_n;
  logic              pc_wr_err_n;
  logic              grant_a, grant_b;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_STATE;
      cnt       <= '0;
      prio      <= PRIO_A;
      we3       <= 1'b0;
      wa3       <= '0;
      wd3       <= '0;
      init_done <= 1'b0;
      pc_wr_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      prio      <= prio_n;
      we3       <= we3_n;
      wa3       <= wa3_n;
      wd3       <= wd3_n;
      init_done <= init_done_n;
      pc_wr_err <= pc_wr_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    prio_n      = prio;
    we3_n       = 1'b0;
    wa3_n       = wa3;
    wd3_n       = wd3;
    init_done_n = init_done;
    pc_wr_err_n = 1'b0;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    sel_addr    = a_addr;
    sel_data    = a_data;

    case (state)
      S_INIT: begin
        we3_n = 1'b1;
        wa3_n = cnt;
        wd3_n = '0;
        cnt_n = cnt + 1'b1;
        if (cnt == LAST_INIT) begin
          state_n     = S_RUN;
          init_done_n = 1'b1;
        end
      end

      S_RUN: begin
        init_done_n = 1'b1;
        // Readies are gated by rst so nothing looks accepted on a reset edge.
        if (!hold && !rst) begin
          grant_a = a_valid && (!b_valid || (prio == PRIO_A));
          grant_b = b_valid && (!a_valid || (prio == PRIO_B));
        end
        if (grant_b) begin
          sel_addr = b_addr;
          sel_data = b_data;
        end
        if (grant_a || grant_b) begin
          prio_n = grant_a ? PRIO_B : PRIO_A;
          if (sel_addr == PC_A) begin
            pc_wr_err_n = 1'b1;
          end else begin
            we3_n = 1'b1;
            wa3_n = sel_addr;
            wd3_n = sel_data;
          end
        end
      end

      default: state_n = RST_STATE;
    endcase
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

endmodule
`default_nettype wire

// File: tb/tb_reg_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reg_wr_arbiter: directed bench for reg_wr_arbiter. Rev 1.0              |
// +----------------------------------------------------------------------------+
module tb_reg_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst, hold;
  logic        a_valid, b_valid;
  logic [3:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, we3, init_done, pc_wr_err;
  logic [3:0]  wa3;
  logic [31:0] wd3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg_wr_arbiter dut (
    .clk(clk), .rst(rst), .hold(hold),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .we3(we3), .wa3(wa3), .wd3(wd3), .init_done(init_done), .pc_wr_err(pc_wr_err)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0;
    a_valid = 1'b1; a_addr = 4'd9; a_data = 32'hAAAA;
    b_valid = 1'b1; b_addr = 4'd10; b_data = 32'hBBBB;
    step(); step();
    vectors++;
    if ({we3, wa3, wd3, init_done, pc_wr_err, a_ready, b_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: we3=%b wa3=%0d wd3=%h init_done=%b err=%b ar=%b br=%b, all 0 required",
               we3, wa3, wd3, init_done, pc_wr_err, a_ready, b_ready);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) begin
      vectors++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL init_ready[%0d]: ar=%b br=%b, 0/0 required", i, a_ready, b_ready);
      end
      if (i == 14) begin a_valid = 1'b0; b_valid = 1'b0; end
      step();
      vectors++;
      if (we3 !== 1'b1 || wa3 !== 4'(i) || wd3 !== 32'h0 || init_done !== (i == 14)) begin
        miscompares++;
        $display("FAIL init_clear[%0d]: we3=%b wa3=%0d wd3=%h init_done=%b, required 1/%0d/0/%b",
                 i, we3, wa3, wd3, init_done, i, (i == 14));
      end
    end
    step();
    vectors++;
    if (we3 !== 1'b0 || init_done !== 1'b1) begin
      miscompares++;
      $display("FAIL init_end: we3=%b init_done=%b, required 0/1", we3, init_done);
    end
  endtask

  task automatic test_single_a();
    a_valid = 1'b1; a_addr = 4'd3; a_data = 32'hFF;
    #1;
    vectors++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_a_ready: ar=%b br=%b, required 1/0", a_ready, b_ready);
    end
    step();
    a_valid = 1'b0;
    vectors++;
    if (we3 !== 1'b1 || wa3 !== 4'd3 || wd3 !== 32'hFF) begin
      miscompares++;
      $display("FAIL single_a_write: we3=%b wa3=%0d wd3=%h, required 1/3/ff", we3, wa3, wd3);
    end
    step();
    vectors++;
    if (we3 !== 1'b0 || wa3 !== 4'd3 || wd3 !== 32'hFF) begin
      miscompares++;
      $display("FAIL single_a_idle: we3=%b wa3=%0d wd3=%h, required 0/3/ff", we3, wa3, wd3);
    end
  endtask

  // Entered with prio=B (A was last granted).
  task automatic test_pc_write();
    a_valid = 1'b1; a_addr = 4'hF; a_data = 32'hDEAD;
    #1;
    vectors++;
    if (a_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pc_ready: ar=%b, required 1", a_ready);
    end
    step();
    vectors++;
    if (we3 !== 1'b0 || pc_wr_err !== 1'b1) begin
      miscompares++;
      $display("FAIL pc_drop: we3=%b pc_wr_err=%b, required 0/1", we3, pc_wr_err);
    end
    a_addr = 4'd5; a_data = 32'h55;
    b_valid = 1'b1; b_addr = 4'd6; b_data = 32'h66;
    #1;
    vectors++;
    if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pc_next_grant: ar=%b br=%b, required 0/1", a_ready, b_ready);
    end
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    vectors++;
    if (pc_wr_err !== 1'b0 || we3 !== 1'b1 || wa3 !== 4'd6 || wd3 !== 32'h66) begin
      miscompares++;
      $display("FAIL pc_after: err=%b we3=%b wa3=%0d wd3=%h, required 0/1/6/66",
               pc_wr_err, we3, wa3, wd3);
    end
  endtask

  // Entered with prio=A.
  task automatic test_back_to_back();
    a_valid = 1'b1; a_addr = 4'd1; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 4'd2; b_data = 32'h22;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (a_ready !== (k % 2 == 0) || b_ready !== (k % 2 == 1)) begin
        miscompares++;
        $display("FAIL alt_ready[%0d]: ar=%b br=%b, required %b/%b",
                 k, a_ready, b_ready, (k % 2 == 0), (k % 2 == 1));
      end
      step();
      vectors++;
      if (we3 !== 1'b1 || wa3 !== ((k % 2 == 0) ? 4'd1 : 4'd2) ||
          wd3 !== ((k % 2 == 0) ? 32'h11 : 32'h22)) begin
        miscompares++;
        $display("FAIL alt_write[%0d]: we3=%b wa3=%0d wd3=%h", k, we3, wa3, wd3);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    vectors++;
    if (we3 !== 1'b0) begin
      miscompares++;
      $display("FAIL alt_idle: we3=%b, required 0", we3);
    end
  endtask

  // Entered with prio=A.
  task automatic test_hold();
    hold = 1'b1;
    a_valid = 1'b1; a_addr = 4'd7; a_data = 32'h77;
    b_valid = 1'b1; b_addr = 4'd8; b_data = 32'h88;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_ready[%0d]: ar=%b br=%b, required 0/0", k, a_ready, b_ready);
      end
      step();
      vectors++;
      if (we3 !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_we3[%0d]: we3=%b, required 0", k, we3);
      end
    end
    hold = 1'b0;
    #1;
    vectors++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: ar=%b br=%b, required 1/0", a_ready, b_ready);
    end
    step();
    vectors++;
    if (we3 !== 1'b1 || wa3 !== 4'd7 || wd3 !== 32'h77 || b_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_first: we3=%b wa3=%0d wd3=%h br=%b, required 1/7/77/1",
               we3, wa3, wd3, b_ready);
    end
  endtask

  // Entered in RUN with both valid and B about to be granted.
  task automatic test_mid_reset();
    rst = 1'b1;
    #1;
    vectors++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_ready: ar=%b br=%b, required 0/0", a_ready, b_ready);
    end
    step();
    vectors++;
    if (we3 !== 1'b0 || init_done !== 1'b0 || wa3 !== 4'd0 || wd3 !== 32'h0 || pc_wr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_outputs: we3=%b init_done=%b wa3=%0d wd3=%h err=%b, required all 0",
               we3, init_done, wa3, wd3, pc_wr_err);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL reinit_ready[%0d]: ar=%b br=%b, required 0/0", i, a_ready, b_ready);
      end
      step();
      vectors++;
      if (we3 !== 1'b1 || wa3 !== 4'(i) || wd3 !== 32'h0 || init_done !== 1'b0) begin
        miscompares++;
        $display("FAIL reinit[%0d]: we3=%b wa3=%0d wd3=%h init_done=%b, required 1/%0d/0/0",
                 i, we3, wa3, wd3, init_done, i);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_a();
    test_pc_write();
    test_back_to_back();
    test_hold();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
- Owns the single write port (we3/wa3/wd3) of the 16-entry, 32-bit register bank.
- Shares that port between two writeback requesters, A (ALU result) and B (load/memory result), using valid/ready handshakes and round-robin priority.
- After reset, sequences a clear of r0..r14 before any requester is served.
- Blocks writes to r15, which the register bank sources externally as the PC.

Parameters:
- DATA_W, 32, data width of the write port and requester payloads.
- ADDR_W, 4, register address width.
- PC_ADDR, 15, protected register address; writes to it are dropped.
- INIT_EN, 1, enables the post-reset clear sequence. When 0, the block enters RUN on the first edge after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- hold  in  1  stall from the core controller; suppresses grants while high.
- a_valid  in  1  requester A has a write pending.
- a_addr  in  ADDR_W  requester A destination register.
- a_data  in  DATA_W  requester A write data.
- a_ready  out  1  requester A is granted this cycle.
- b_valid  in  1  requester B has a write pending.
- b_addr  in  ADDR_W  requester B destination register.
- b_data  in  DATA_W  requester B write data.
- b_ready  out  1  requester B is granted this cycle.
- we3  out  1  register bank write enable (registered).
- wa3  out  ADDR_W  register bank write address (registered).
- wd3  out  DATA_W  register bank write data (registered).
- init_done  out  1  high once the clear sequence has completed.
- pc_wr_err  out  1  one-cycle pulse when a write to PC_ADDR is dropped.

Behaviour:
- Reset: rst is sampled at the clock edge only.
  - While rst=1: we3=0, wa3=0, wd3=0, init_done=0, pc_wr_err=0, a_ready=0, b_ready=0.
  - Internal state is set to: state=INIT (or RUN if INIT_EN=0), cnt=0, prio=A.
- FSM states: INIT, RUN.
- INIT:
  - Each edge loads we3=1, wa3=cnt, wd3=0, then cnt increments.
  - On the edge that loads wa3=14: state goes to RUN and init_done=1 on that same edge.
  - Result: exactly 15 consecutive write cycles, one each for r0..r14. r15 is never written.
  - a_ready=b_ready=0 for the whole of INIT. hold is ignored in INIT.
- RUN grant logic (combinational from valids, hold, prio):
  - hold=1: no grant.
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the side named by prio.
  - x_ready = grant to x. At most one ready is high in any cycle.
- Acceptance: x_valid & x_ready at an edge.
  - Next cycle (1-cycle latency): we3=1, wa3=x_addr, wd3=x_data.
  - Exception: if x_addr==PC_ADDR, the write is dropped. Next cycle we3=0 and pc_wr_err=1 for one cycle. The grant and prio update still happen.
- No acceptance at an edge: we3=0 next cycle. wa3 and wd3 hold their previous values. pc_wr_err=0.
- prio update:
  - After a grant to A, prio=B. After a grant to B, prio=A.
  - Unchanged when there is no grant, including while hold=1.
- Requesters may hold valid high across cycles. Payload must stay stable until accepted. The arbiter is throughput 1 write per cycle.
- Same address from A and B in one cycle: served in prio order. The later write wins in the register bank.
- Reset mid-operation (rst=1 in any state): outputs return to reset values on that edge. Any in-flight accepted write not yet presented is discarded. On release, INIT restarts from wa3=0.
- init_done remains 1 throughout RUN and clears only on rst.

Test Plan:
1. rst=1 for 2 cycles, then 0 with a_valid=b_valid=1 -> we3=1 for 15 cycles with wa3=0,1,…,14 and wd3=0. init_done rises on the same edge as wa3=14. a_ready=b_ready=0 throughout INIT.
2. After init, only A valid with a_addr=3, a_data=32'hFF -> a_ready=1. Next cycle we3=1, wa3=3, wd3=32'hFF. The cycle after, we3=0 once a_valid drops.
3. Both valid continuously (A: addr 1, data 32'h11; B: addr 2, data 32'h22) -> readies alternate A,B,A,B starting with A. we3=1 every cycle. wa3 sequence is 1,2,1,2 and wd3 sequence is 11,22,11,22.
4. A valid with a_addr=4'hF, a_data=32'hDEAD -> a_ready=1. Next cycle we3=0 and pc_wr_err=1 for exactly one cycle. The following B request is granted even if A is valid again.
5. Both valid, hold=1 for 3 cycles -> both readies 0 and we3=0 for those cycles. On hold=0, the first grant goes to the side prio held before the hold, i.e. prio is unchanged by hold.
6. In RUN with both valid, assert rst for 1 cycle -> at that edge we3=0, init_done=0, readies 0. After release, INIT restarts with wa3=0.
